if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- IF stage plus IF/ID pipeline register, directly upstream of the ID link/branch mux.
- Owns the fetch PC and issues req/ack reads to instruction memory.
- Delivers id_pc/id_instr/id_valid to ID; id_pc is the pc that ID uses to form the pc+4 link value.
- Applies ID-resolved branch/jump redirects (no delay slot, so the wrong-path IF instruction is squashed) and honours hazard-unit stalls.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven on bubbles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  hazard unit: hold IF/ID contents, do not advance
- redirect  input  1  ID: branch taken or jump/jr, target valid
- redirect_target  input  32  ID-computed next PC
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address, stable while imem_req=1 and no ack
- imem_ack  input  1  read complete, imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction
- id_pc  output  32  PC of instruction in ID
- id_instr  output  32  instruction in ID
- id_valid  output  1  id_instr is a real instruction (0 = bubble)

Behaviour:
- Reset values:
  - id_pc=0, id_instr=NOP_INSTR, id_valid=0, imem_req=0.
  - fetch_pc=RESET_PC, state=FETCH, buffer empty.
- First request is issued the cycle after rst deasserts. An outstanding transaction is abandoned on reset; memory must tolerate req dropping.
- Internal registers:
  - fetch_pc: next address to fetch.
  - req_pc: drives imem_addr; loaded from fetch_pc when a request starts.
  - buf_pc/buf_instr: one-entry hold buffer.
- Arithmetic:
  - fetch_pc+4 is mod 2^32 (32'hFFFF_FFFC -> 0).
  - redirect_target[1:0] is forced to 2'b00.
- imem_req=1 in FETCH and DRAIN; 0 in HOLD.
- Minimum latency: one-cycle ack memory gives one instruction per cycle. IF/ID updates on the edge where ack is seen.
- redirect is ignored while stall=1, because an ID result is not final when ID is stalled.
- State FETCH:
  - ack=1, stall=0, redirect=0: IF/ID <= {req_pc, rdata, valid 1}; fetch_pc += 4; new request next cycle.
  - ack=1, stall=1: IF/ID holds; buffer <= {req_pc, rdata}; fetch_pc += 4; go HOLD.
  - ack=1, redirect=1 (stall=0): rdata discarded; IF/ID <= bubble; fetch_pc <= target; stay FETCH.
  - ack=0, redirect=1 (stall=0): IF/ID <= bubble; fetch_pc <= target; go DRAIN with req_pc unchanged.
  - ack=0, stall=0, no redirect: IF/ID <= bubble.
  - ack=0, stall=1: IF/ID holds.
- State HOLD:
  - stall=1: everything holds.
  - stall=0, redirect=0: IF/ID <= buffer with valid 1; go FETCH.
  - stall=0, redirect=1: buffer discarded; IF/ID <= bubble; fetch_pc <= target; go FETCH.
- State DRAIN:
  - Keep req on old req_pc until ack.
  - On ack: discard rdata; go FETCH; next request uses the redirected fetch_pc.
  - Bubbles go to ID unless stall=1.
  - A further redirect in DRAIN overwrites fetch_pc; the last one wins.
- Bubble: id_valid=0, id_instr=NOP_INSTR, id_pc unchanged.
- No instruction may be delivered twice or skipped; each acked word reaches ID exactly once or is squashed by redirect.

Decomposition:
- Shared package (cpu_defines): state encodings FETCH/HOLD/DRAIN, RESET_PC default, NOP_INSTR.
- One sub-module: if_id_reg, the 32+32+1 pipeline register with load/hold/bubble controls, reused pattern for later stage registers.
- FSM and PC logic stay in if_fetch_unit.

Test Plan:
- Reset with a zero-wait memory: rst high 3 cycles then low -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles. id_valid rises one cycle after the first ack; id_pc follows 0x3000, 0x3004.
- Stall on the ack cycle for 3 cycles -> id_pc/id_instr frozen, imem_req=0 during HOLD. On release the buffered word at 0x3008 appears with id_valid=1, then the fetch at 0x300C.
- redirect=1, target 0x3100, with a same-cycle ack of 0x3008 -> 0x3008 never reaches ID (one bubble), next imem_addr=0x3100.
- 2-wait-state memory, redirect to 0x3200 while a request to 0x3010 is pending -> imem_addr stays 0x3010 until ack, data is dropped, next request is 0x3200.
- redirect asserted with stall=1 -> ignored; fetch sequence is unchanged. Target 0x3203 -> fetch address 0x3200.
- Wrap: RESET_PC=32'hFFFF_FFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. rst pulsed mid-DRAIN -> next request is at RESET_PC, id_valid=0.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings and
// default reset PC / bubble instruction values.
package if_fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_3000;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: hazard/redirect controls from ID, the instruction
// memory req/ack channel and the IF/ID outputs toward ID.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;
    logic            id_valid;

    modport master (
        input  stall, redirect, redirect_target, imem_ack, imem_rdata,
        output imem_req, imem_addr, id_pc, id_instr, id_valid
    );

    modport slave (
        output stall, redirect, redirect_target, imem_ack, imem_rdata,
        input  imem_req, imem_addr, id_pc, id_instr, id_valid
    );

endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: pc + instruction + valid, with load, hold and
// bubble controls. Load has priority over bubble; neither means hold.
module if_id_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] pc_p0,
    input  logic [XLEN-1:0] instr_p0,
    output logic [XLEN-1:0] pc_p1,
    output logic [XLEN-1:0] instr_p1,
    output logic            vld_p1
);

    // IF -> ID stage boundary; a bubble keeps pc_p1 so ID still sees the last pc
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p1    <= '0;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
        end else if (load) begin
            pc_p1    <= pc_p0;
            instr_p1 <= instr_p0;
            vld_p1   <= 1'b1;
        end else if (bubble) begin
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the fetch PC, runs the imem req/ack handshake, applies ID
// redirects and hazard stalls, and feeds the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_unit_if.master  bus
);

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
        return t & ~32'h0000_0003;
    endfunction

    fetch_state_t    state, state_nxt;
    logic            started;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0] req_pc, req_pc_nxt;
    logic [XLEN-1:0] buf_pc, buf_instr;

    logic            ack;
    logic            redir;
    logic [XLEN-1:0] tgt;
    logic            buf_load;
    logic            ifid_load;
    logic            ifid_bubble;
    logic            ifid_from_buf;
    logic [XLEN-1:0] ifid_pc_p0;
    logic [XLEN-1:0] ifid_instr_p0;

    // started holds off the first request until the cycle after reset is released
    assign bus.imem_req  = started && (state != HOLD);
    assign bus.imem_addr = req_pc;

    assign ack   = bus.imem_ack && bus.imem_req;
    assign redir = bus.redirect && !bus.stall;
    assign tgt   = align_target(bus.redirect_target);

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        buf_load      = 1'b0;
        ifid_load     = 1'b0;
        ifid_bubble   = 1'b0;
        ifid_from_buf = 1'b0;

        if (started) begin
            unique case (state)
                FETCH: begin
                    if (bus.stall) begin
                        if (ack) begin
                            buf_load     = 1'b1;
                            fetch_pc_nxt = pc_inc(fetch_pc);
                            state_nxt    = HOLD;
                        end
                    end else if (redir) begin
                        // Wrong-path word (if any) is dropped; a pending read must drain first
                        ifid_bubble  = 1'b1;
                        fetch_pc_nxt = tgt;
                        if (!ack) begin
                            state_nxt = DRAIN;
                        end
                    end else if (ack) begin
                        ifid_load    = 1'b1;
                        fetch_pc_nxt = pc_inc(fetch_pc);
                    end else begin
                        ifid_bubble = 1'b1;
                    end
                end

                HOLD: begin
                    if (!bus.stall) begin
                        state_nxt = FETCH;
                        if (redir) begin
                            ifid_bubble  = 1'b1;
                            fetch_pc_nxt = tgt;
                        end else begin
                            ifid_load     = 1'b1;
                            ifid_from_buf = 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (ack) begin
                        state_nxt = FETCH;
                    end
                    if (!bus.stall) begin
                        ifid_bubble = 1'b1;
                        if (redir) begin
                            fetch_pc_nxt = tgt;
                        end
                    end
                end

                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end

        // A draining read keeps its address; otherwise the next request targets fetch_pc
        req_pc_nxt = (state_nxt == DRAIN) ? req_pc : fetch_pc_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            started  <= 1'b0;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_nxt;
            started  <= 1'b1;
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
        end
    end

    // Hold buffer contents are only meaningful in HOLD, so they carry no reset
    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_pc    <= req_pc;
            buf_instr <= bus.imem_rdata;
        end
    end

    assign ifid_pc_p0    = ifid_from_buf ? buf_pc    : req_pc;
    assign ifid_instr_p0 = ifid_from_buf ? buf_instr : bus.imem_rdata;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .pc_p0    (ifid_pc_p0),
        .instr_p0 (ifid_instr_p0),
        .pc_p1    (bus.id_pc),
        .instr_p1 (bus.id_instr),
        .vld_p1   (bus.id_valid)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: wait-state memory model, stalls,
// redirects, drain, reset mid-transaction and PC wrap on a second instance.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   total = 0;
    int   bad   = 0;
    int   waits = 0;
    int   wcnt  = 0;
    int   wcnt2 = 0;

    if_fetch_unit_if bus ();
    if_fetch_unit_if bus2 ();

    if_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    if_fetch_unit #(
        .RESET_PC  (32'hFFFF_FFF8),
        .NOP_INSTR (32'h0000_0000)
    ) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Memory: ack after 'waits' idle request cycles; data word = {addr[15:0], C0DE}
    assign bus.imem_ack   = bus.imem_req && (wcnt == waits);
    assign bus.imem_rdata = {bus.imem_addr[15:0], 16'hC0DE};
    always @(posedge clk) wcnt <= (bus.imem_req && !bus.imem_ack) ? wcnt + 1 : 0;

    assign bus2.imem_ack   = bus2.imem_req && (wcnt2 == 0);
    assign bus2.imem_rdata = {bus2.imem_addr[15:0], 16'hC0DE};
    always @(posedge clk) wcnt2 <= (bus2.imem_req && !bus2.imem_ack) ? wcnt2 + 1 : 0;

    function automatic logic [97:0] snap();
        return {bus.imem_req, (bus.imem_req ? bus.imem_addr : 32'h0),
                bus.id_valid, bus.id_pc, bus.id_instr};
    endfunction

    function automatic logic [97:0] snap2();
        return {bus2.imem_req, (bus2.imem_req ? bus2.imem_addr : 32'h0),
                bus2.id_valid, bus2.id_pc, bus2.id_instr};
    endfunction

    function automatic logic [97:0] ev(input logic r, input logic [31:0] a, input logic v,
                                       input logic [31:0] p, input logic [31:0] i);
        return {r, a, v, p, i};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int w);
        rst = 1'b1;
        waits = w;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'h0;
        step(); step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [97:0] exp;
        do_reset(0);
        exp = ev(0, 32'h0, 0, 32'h0, 32'h0);
        total++; if (snap() !== exp) begin bad++; $display("FAIL reset_vals got %h want %h", snap(), exp); end
        step();
        exp = ev(1, 32'h3000, 0, 32'h0, 32'h0);
        total++; if (snap() !== exp) begin bad++; $display("FAIL first_req got %h want %h", snap(), exp); end
        step();
        exp = ev(1, 32'h3004, 1, 32'h3000, 32'h3000_C0DE);
        total++; if (snap() !== exp) begin bad++; $display("FAIL first_id got %h want %h", snap(), exp); end
        step();
        exp = ev(1, 32'h3008, 1, 32'h3004, 32'h3004_C0DE);
        total++; if (snap() !== exp) begin bad++; $display("FAIL second_id got %h want %h", snap(), exp); end
    endtask

    task automatic test_stall();
        logic [97:0] exp;
        do_reset(0);
        step(); step(); step();
        bus.stall = 1'b1;
        exp = ev(0, 32'h0, 1, 32'h3004, 32'h3004_C0DE);
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (snap() !== exp) begin bad++; $display("FAIL stall_hold%0d got %h want %h", k, snap(), exp); end
        end
        bus.stall = 1'b0;
        step();
        exp = ev(1, 32'h300C, 1, 32'h3008, 32'h3008_C0DE);
        total++; if (snap() !== exp) begin bad++; $display("FAIL stall_release got %h want %h", snap(), exp); end
        step();
        exp = ev(1, 32'h3010, 1, 32'h300C, 32'h300C_C0DE);
        total++; if (snap() !== exp) begin bad++; $display("FAIL stall_after got %h want %h", snap(), exp); end
    endtask

    task automatic test_redirect_ack();
        logic [97:0] exp;
        do_reset(0);
        step(); step(); step();
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h3100;
        step();
        bus.redirect = 1'b0;
        exp = ev(1, 32'h3100, 0, 32'h3004, 32'h0);
        total++; if (snap() !== exp) begin bad++; $display("FAIL redir_squash got %h want %h", snap(), exp); end
        step();
        exp = ev(1, 32'h3104, 1, 32'h3100, 32'h3100_C0DE);
        total++; if (snap() !== exp) begin bad++; $display("FAIL redir_target got %h want %h", snap(), exp); end
    endtask

    task automatic test_drain();
        logic [97:0] exp;
        do_reset(0);
        step(); step(); step(); step(); step();
        waits = 2;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h3200;
        step();
        exp = ev(1, 32'h3010, 0, 32'h300C, 32'h0);
        total++; if (snap() !== exp) begin bad++; $display("FAIL drain_enter got %h want %h", snap(), exp); end
        bus.redirect_target = 32'h3240;
        step();
        bus.redirect = 1'b0;
        total++; if (snap() !== exp) begin bad++; $display("FAIL drain_wait got %h want %h", snap(), exp); end
        exp = ev(1, 32'h3240, 0, 32'h300C, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (snap() !== exp) begin bad++; $display("FAIL drain_newreq%0d got %h want %h", k, snap(), exp); end
        end
        step();
        exp = ev(1, 32'h3244, 1, 32'h3240, 32'h3240_C0DE);
        total++; if (snap() !== exp) begin bad++; $display("FAIL drain_deliver got %h want %h", snap(), exp); end
    endtask

    task automatic test_stall_redirect();
        logic [97:0] exp;
        do_reset(0);
        step(); step(); step();
        bus.stall = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h3100;
        exp = ev(0, 32'h0, 1, 32'h3004, 32'h3004_C0DE);
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (snap() !== exp) begin bad++; $display("FAIL stallredir_hold%0d got %h want %h", k, snap(), exp); end
        end
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        step();
        exp = ev(1, 32'h300C, 1, 32'h3008, 32'h3008_C0DE);
        total++; if (snap() !== exp) begin bad++; $display("FAIL stallredir_ignored got %h want %h", snap(), exp); end
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h3203;
        step();
        bus.redirect = 1'b0;
        exp = ev(1, 32'h3200, 0, 32'h3008, 32'h0);
        total++; if (snap() !== exp) begin bad++; $display("FAIL target_align got %h want %h", snap(), exp); end
        step();
        exp = ev(1, 32'h3204, 1, 32'h3200, 32'h3200_C0DE);
        total++; if (snap() !== exp) begin bad++; $display("FAIL align_deliver got %h want %h", snap(), exp); end
    endtask

    task automatic test_hold_redirect();
        logic [97:0] exp;
        do_reset(0);
        step(); step(); step();
        bus.stall = 1'b1;
        step();
        bus.stall = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h3300;
        step();
        bus.redirect = 1'b0;
        exp = ev(1, 32'h3300, 0, 32'h3004, 32'h0);
        total++; if (snap() !== exp) begin bad++; $display("FAIL hold_redir_drop got %h want %h", snap(), exp); end
        step();
        exp = ev(1, 32'h3304, 1, 32'h3300, 32'h3300_C0DE);
        total++; if (snap() !== exp) begin bad++; $display("FAIL hold_redir_deliver got %h want %h", snap(), exp); end
    endtask

    task automatic test_reset_in_drain();
        logic [97:0] exp;
        do_reset(2);
        step();
        exp = ev(1, 32'h3000, 0, 32'h0, 32'h0);
        total++; if (snap() !== exp) begin bad++; $display("FAIL rdrain_req got %h want %h", snap(), exp); end
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h3400;
        step();
        bus.redirect = 1'b0;
        total++; if (snap() !== exp) begin bad++; $display("FAIL rdrain_drain got %h want %h", snap(), exp); end
        rst = 1'b1;
        step();
        exp = ev(0, 32'h0, 0, 32'h0, 32'h0);
        total++; if (snap() !== exp) begin bad++; $display("FAIL rdrain_abandon got %h want %h", snap(), exp); end
        rst = 1'b0;
        step();
        exp = ev(1, 32'h3000, 0, 32'h0, 32'h0);
        total++; if (snap() !== exp) begin bad++; $display("FAIL rdrain_restart got %h want %h", snap(), exp); end
        step(); step(); step();
        exp = ev(1, 32'h3004, 1, 32'h3000, 32'h3000_C0DE);
        total++; if (snap() !== exp) begin bad++; $display("FAIL rdrain_deliver got %h want %h", snap(), exp); end
    endtask

    task automatic test_wrap();
        logic [97:0] exp;
        rst2 = 1'b1;
        step(); step();
        rst2 = 1'b0;
        step();
        exp = ev(1, 32'hFFFF_FFF8, 0, 32'h0, 32'h0);
        total++; if (snap2() !== exp) begin bad++; $display("FAIL wrap_first got %h want %h", snap2(), exp); end
        step();
        exp = ev(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 32'hFFF8_C0DE);
        total++; if (snap2() !== exp) begin bad++; $display("FAIL wrap_second got %h want %h", snap2(), exp); end
        step();
        exp = ev(1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'hFFFC_C0DE);
        total++; if (snap2() !== exp) begin bad++; $display("FAIL wrap_zero got %h want %h", snap2(), exp); end
        step();
        exp = ev(1, 32'h0000_0004, 1, 32'h0000_0000, 32'h0000_C0DE);
        total++; if (snap2() !== exp) begin bad++; $display("FAIL wrap_after got %h want %h", snap2(), exp); end
    endtask

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'h0;
        bus2.stall = 1'b0;
        bus2.redirect = 1'b0;
        bus2.redirect_target = 32'h0;
        #1;
        test_reset();
        test_stall();
        test_redirect_ack();
        test_drain();
        test_stall_redirect();
        test_hold_redirect();
        test_reset_in_drain();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
